// File: rtl/sti_dac_pkg.sv
// rtl/sti_dac_pkg.sv - shared types and decode helpers for the sti_dac_gen serial/DAC-memory writer
package sti_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FLUSH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] addr;
    logic        par;
  } bank_map_t;

  function automatic logic [31:0] frame_bytes(input logic [31:0] len);
    return len + 32'd1;
  endfunction

  // Even/odd selection flips every ROW_BYTES bytes to form the checkerboard.
  function automatic bank_map_t bank_decode(input logic [31:0] b,
                                            input logic [31:0] depth,
                                            input logic [31:0] row_bytes);
    bank_map_t   m;
    logic [31:0] row;
    row    = b / row_bytes;
    m.bank = b / (32'd2 * depth);
    m.addr = (b % (32'd2 * depth)) >> 1;
    m.par  = b[0] ^ row[0];
    return m;
  endfunction

endpackage

// File: rtl/sti_dac_bank_map.sv
// rtl/sti_dac_bank_map.sv - combinational byte-counter to {bank, parity, entry address} map
module sti_dac_bank_map
  import sti_dac_pkg::*;
#(
  parameter int BANKS     = 4,
  parameter int DEPTH     = 32,
  parameter int ROW_BYTES = 8,
  parameter int BW        = 9,
  parameter int AW        = 5,
  parameter int BKW       = 2
) (
  input  logic [BW-1:0]  i_b,
  output logic [BKW-1:0] o_bank,
  output logic           o_par,
  output logic [AW-1:0]  o_addr
);

  bank_map_t w_map;
  logic      w_unused;

  assign w_map    = bank_decode(32'(i_b), 32'(DEPTH), 32'(ROW_BYTES));
  assign o_bank   = w_map.bank[BKW-1:0];
  assign o_par    = w_map.par;
  assign o_addr   = w_map.addr[AW-1:0];
  assign w_unused = ^{w_map.bank[31:BKW], w_map.addr[31:AW]};

endmodule

// File: rtl/sti_dac_gen.sv
// rtl/sti_dac_gen.sv - serial frame transmitter with byte packer and checkerboard DAC-memory writer
// Optional end-of-stream zero-fill of unwritten memory: STI_DAC_ZERO_FILL_EN
module sti_dac_gen
  import sti_dac_pkg::*;
#(
  parameter int  IN_W      = 16,
  parameter int  LEN_W     = 2,
  parameter int  BANKS     = 4,
  parameter int  DEPTH     = 32,
  parameter int  ROW_BYTES = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [IN_W-1:0]  pi_data,
  input  logic [LEN_W-1:0] pi_length,
  input  logic             pi_fill,
  input  logic             pi_msb,
  input  logic             pi_low,
  input  logic             pi_end,
  output logic             busy,
  output logic             so_data,
  output logic             so_valid,
  output logic [7:0]       oem_dataout,
  output logic [AW-1:0]    oem_addr,
  output logic [BANKS-1:0] odd_wr,
  output logic [BANKS-1:0] even_wr,
  output logic             oem_finish
);

  localparam int MAXW = 8 * (1 << LEN_W);
  localparam int WW   = (MAXW > IN_W) ? MAXW : IN_W;
  localparam int CW   = $clog2(WW) + 1;
  localparam int TOT  = 2 * BANKS * DEPTH;
  localparam int BW   = $clog2(TOT) + 1;
  localparam int BKW  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [CW-1:0] C_IN_W = CW'(IN_W);
  localparam logic [CW-1:0] C_WW   = CW'(WW);
  localparam logic [BW-1:0] C_TOT  = BW'(TOT);

  state_t         r_state, w_state_nxt;
  logic           w_load_acc;
  logic [31:0]    w_fbytes;
  logic [CW-1:0]  w_fb;
  logic [WW-1:0]  w_data_ext, w_frame, w_aligned;
  logic [WW-1:0]  r_sh;
  logic [CW-1:0]  r_left;
  logic           r_msb;
  logic [6:0]     r_byte;
  logic [2:0]     r_bcnt;
  logic [BW-1:0]  r_b;
  logic [BKW-1:0] w_bank;
  logic           w_par;
  logic [AW-1:0]  w_addr;
  logic [BANKS-1:0] w_onehot;
  logic           w_byte_wr, w_wr;
  logic [7:0]     w_wr_data;
`ifdef STI_DAC_ZERO_FILL_EN
  logic           w_flush_wr;
`endif

  assign w_fbytes   = frame_bytes(32'(pi_length));
  assign w_fb       = CW'(w_fbytes << 3);
  assign w_data_ext = WW'(pi_data);

  always_comb begin
    w_frame = '0;
    if (w_fb <= C_IN_W) begin
      if (pi_low) w_frame = w_data_ext >> (C_IN_W - w_fb);
      else        w_frame = w_data_ext & ~({WW{1'b1}} << w_fb);
    end else begin
      if (pi_fill) w_frame = w_data_ext << (w_fb - C_IN_W);
      else         w_frame = w_data_ext;
    end
  end

  // MSB-first frames are left-justified so both directions shift from a fixed end.
  assign w_aligned = pi_msb ? (w_frame << (C_WW - w_fb)) : w_frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load) w_state_nxt = ST_SHIFT;
`ifdef STI_DAC_ZERO_FILL_EN
        else if (pi_end) w_state_nxt = ST_FLUSH;
`else
        else if (pi_end) w_state_nxt = ST_DONE;
`endif
      end
      ST_SHIFT: if (r_left == '0) w_state_nxt = ST_IDLE;
`ifdef STI_DAC_ZERO_FILL_EN
      ST_FLUSH: if (r_b == C_TOT) w_state_nxt = ST_DONE;
`endif
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    busy       = (r_state != ST_IDLE);
    w_load_acc = (r_state == ST_IDLE) && load;
`ifdef STI_DAC_ZERO_FILL_EN
    w_flush_wr = (r_state == ST_FLUSH) && (r_b != C_TOT);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) oem_finish <= 1'b0;
    else          oem_finish <= (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh     <= '0;
      r_left   <= '0;
      r_msb    <= 1'b0;
      so_data  <= 1'b0;
      so_valid <= 1'b0;
    end else if (w_load_acc) begin
      r_msb    <= pi_msb;
      so_valid <= 1'b1;
      r_left   <= w_fb - CW'(1);
      if (pi_msb) begin
        so_data <= w_aligned[WW-1];
        r_sh    <= w_aligned << 1;
      end else begin
        so_data <= w_aligned[0];
        r_sh    <= w_aligned >> 1;
      end
    end else if (r_state == ST_SHIFT) begin
      if (r_left != '0) begin
        r_left <= r_left - CW'(1);
        if (r_msb) begin
          so_data <= r_sh[WW-1];
          r_sh    <= r_sh << 1;
        end else begin
          so_data <= r_sh[0];
          r_sh    <= r_sh >> 1;
        end
      end else begin
        so_valid <= 1'b0;
        so_data  <= 1'b0;
      end
    end
  end

  sti_dac_bank_map #(
    .BANKS     (BANKS),
    .DEPTH     (DEPTH),
    .ROW_BYTES (ROW_BYTES),
    .BW        (BW),
    .AW        (AW),
    .BKW       (BKW)
  ) u_bank_map (
    .i_b    (r_b),
    .o_bank (w_bank),
    .o_par  (w_par),
    .o_addr (w_addr)
  );

  assign w_byte_wr = so_valid && (r_bcnt == 3'd7);
  assign w_onehot  = BANKS'(1) << w_bank;
`ifdef STI_DAC_ZERO_FILL_EN
  assign w_wr      = (w_byte_wr || w_flush_wr) && (r_b != C_TOT);
  assign w_wr_data = w_flush_wr ? 8'h00 : {r_byte, so_data};
`else
  assign w_wr      = w_byte_wr && (r_b != C_TOT);
  assign w_wr_data = {r_byte, so_data};
`endif

  // The packer watches the registered serial output, so each write trails its 8th bit by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte      <= '0;
      r_bcnt      <= '0;
      r_b         <= '0;
      oem_dataout <= '0;
      oem_addr    <= '0;
      odd_wr      <= '0;
      even_wr     <= '0;
    end else begin
      odd_wr  <= '0;
      even_wr <= '0;
      if (so_valid) begin
        r_byte <= {r_byte[5:0], so_data};
        r_bcnt <= r_bcnt + 3'd1;
      end
      if (w_wr) begin
        oem_dataout <= w_wr_data;
        oem_addr    <= w_addr;
        if (w_par) odd_wr  <= w_onehot;
        else       even_wr <= w_onehot;
        r_b <= r_b + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sti_dac_gen.sv
// tb/tb_sti_dac_gen.sv - randomized and directed self-checking bench for sti_dac_gen
module tb_sti_dac_gen;

  localparam int IN_W = 16, LEN_W = 2, BANKS = 4, DEPTH = 32, ROW_BYTES = 8, AW = 5;
  localparam int TOT = 2 * BANKS * DEPTH;

  logic             clk = 1'b0, reset_n = 1'b0, load = 1'b0;
  logic [IN_W-1:0]  pi_data = '0;
  logic [LEN_W-1:0] pi_length = '0;
  logic             pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
  logic             busy, so_data, so_valid, oem_finish;
  logic [7:0]       oem_dataout;
  logic [AW-1:0]    oem_addr;
  logic [BANKS-1:0] odd_wr, even_wr;

  sti_dac_gen #(
    .IN_W(IN_W), .LEN_W(LEN_W), .BANKS(BANKS), .DEPTH(DEPTH), .ROW_BYTES(ROW_BYTES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .busy(busy), .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
    .oem_addr(oem_addr), .odd_wr(odd_wr), .even_wr(even_wr), .oem_finish(oem_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; int bank; int addr; int data; bit par; bit bad; int b;
  } wr_t;

  bit  obs_bits[$];
  int  obs_cyc[$];
  wr_t obs_wr[$];
  bit  exp_bits[$];
  wr_t exp_wr[$];

  int  checks = 0, errors = 0, model_b = 0;
  wr_t wr8, wr255;
  bit  got8 = 1'b0, got255 = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    if (so_valid) begin
      obs_bits.push_back(so_data);
      obs_cyc.push_back(cyc);
    end
    if ((odd_wr | even_wr) != '0) begin
      w.cyc  = cyc;
      w.par  = (odd_wr != '0);
      w.bank = 0;
      for (int i = 0; i < BANKS; i++) if (odd_wr[i] | even_wr[i]) w.bank = i;
      w.addr = int'(oem_addr);
      w.data = int'(oem_dataout);
      w.bad  = ($countones({odd_wr, even_wr}) != 1);
      w.b    = 0;
      obs_wr.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: frame bit k from the capture rules, then byte packing and address decode by arithmetic.
  task automatic build_model(input logic [IN_W-1:0] data, input int len, input bit fill,
                             input bit msb, input bit low, input int t);
    int fb, k, v, byt, bb;
    wr_t w;
    fb = 8 * (len + 1);
    exp_bits.delete();
    exp_wr.delete();
    for (int i = 0; i < fb; i++) begin
      k = msb ? (fb - 1 - i) : i;
      if (fb <= IN_W)  v = low ? int'(data[IN_W - fb + k]) : int'(data[k]);
      else if (fill)   v = (k >= fb - IN_W) ? int'(data[k - (fb - IN_W)]) : 0;
      else             v = (k < IN_W) ? int'(data[k]) : 0;
      exp_bits.push_back(v[0]);
    end
    for (int j = 0; j < fb / 8; j++) begin
      byt = 0;
      for (int b = 0; b < 8; b++) byt = byt * 2 + int'(exp_bits[8 * j + b]);
      bb = model_b;
      if (bb < TOT) begin
        w.cyc  = t + 8 * j + 9;
        w.bank = bb / (2 * DEPTH);
        w.addr = (bb % (2 * DEPTH)) / 2;
        w.par  = ((bb % 2) ^ ((bb / ROW_BYTES) % 2)) != 0;
        w.data = byt;
        w.bad  = 1'b0;
        w.b    = bb;
        exp_wr.push_back(w);
        model_b++;
      end
    end
  endtask

  // Entered and left at negedge+1 of an idle cycle, so consecutive calls run back-to-back.
  task automatic run_frame(input logic [IN_W-1:0] data, input int len, input bit fill,
                           input bit msb, input bit low, input bit with_end, input bit poke);
    int t, fb, waitn, mism;
    bit done;
    fb = 8 * (len + 1);
    obs_bits.delete(); obs_cyc.delete(); obs_wr.delete();
    pi_data = data; pi_length = LEN_W'(len); pi_fill = fill; pi_msb = msb; pi_low = low;
    pi_end = with_end; load = 1'b1;
    t = cyc;
    build_model(data, len, fill, msb, low, t);
    @(posedge clk); #1;
    load = 1'b0; pi_end = 1'b0;
    waitn = 0; done = 1'b0;
    while (!done && waitn < 64) begin
      @(negedge clk); #1;
      waitn++;
      if (!busy) done = 1'b1;
      if (poke && waitn == 3) begin
        load = 1'b1; pi_end = 1'b1; pi_data = IN_W'($urandom);
      end else begin
        load = 1'b0; pi_end = 1'b0;
      end
    end
    chk("busy_timeout", done, 1);
    chk("busy_fall", cyc, t + fb + 1);
    chk("nbits", obs_bits.size(), fb);
    mism = 0;
    for (int i = 0; i < fb && i < obs_bits.size(); i++)
      if (obs_bits[i] !== exp_bits[i] || obs_cyc[i] != t + 1 + i) mism++;
    chk("bits", mism, 0);
    chk("nwr", obs_wr.size(), exp_wr.size());
    mism = 0;
    for (int j = 0; j < exp_wr.size() && j < obs_wr.size(); j++) begin
      if (obs_wr[j].cyc != exp_wr[j].cyc || obs_wr[j].bank != exp_wr[j].bank ||
          obs_wr[j].addr != exp_wr[j].addr || obs_wr[j].par != exp_wr[j].par ||
          obs_wr[j].data != exp_wr[j].data || obs_wr[j].bad) mism++;
      if (exp_wr[j].b == 8)   begin wr8 = obs_wr[j];   got8 = 1'b1;   end
      if (exp_wr[j].b == 255) begin wr255 = obs_wr[j]; got255 = 1'b1; end
    end
    chk("wr", mism, 0);
    chk("finish_low", oem_finish, 0);
  endtask

  initial begin
    int s, n, mism, b0;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n, mism, b0;
    logic [31:0] packed_bytes;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_outputs", {busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);

    run_frame(16'hA5C3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    if (obs_wr.size() > 0) begin
      chk("f1_data", obs_wr[0].data, 8'hA5);
      chk("f1_even", obs_wr[0].par, 0);
      chk("f1_addr", obs_wr[0].addr, 0);
    end

    run_frame(16'h0001, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (obs_bits.size() > 0) chk("f2_first_bit", obs_bits[0], 1);
    if (obs_wr.size() > 1) begin
      chk("f2_byte0", obs_wr[0].data, 8'h80);
      chk("f2_byte1", obs_wr[1].data, 8'h00);
    end

    run_frame(16'hFFFF, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (obs_wr.size() > 3) begin
      packed_bytes = {obs_wr[0].data[7:0], obs_wr[1].data[7:0], obs_wr[2].data[7:0], obs_wr[3].data[7:0]};
      chk("f3_bytes", packed_bytes, 32'h0000FFFF);
    end

    run_frame(IN_W'($urandom), 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("load_wins_busy", busy, 0);

    obs_bits.delete(); obs_cyc.delete(); obs_wr.delete();
    pi_data = IN_W'($urandom); pi_length = 2'd1; pi_msb = 1'b1; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("abort_outputs", {busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);
    chk("abort_bits_seen", obs_bits.size(), 5);
    @(negedge clk); #1 reset_n = 1'b1;
    model_b = 0;

    while (model_b < TOT)
      run_frame(IN_W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    run_frame(IN_W'($urandom), 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_serial_continues", obs_bits.size(), 32);
    chk("full_no_write", obs_wr.size(), 0);
    chk("b8_seen", got8, 1);
    chk("b8_odd", wr8.par, 1);
    chk("b8_bank", wr8.bank, 0);
    chk("b8_addr", wr8.addr, 4);
    chk("b255_seen", got255, 1);
    chk("b255_bank", wr255.bank, 3);
    chk("b255_addr", wr255.addr, 31);

    #1 reset_n = 1'b0;
    #1 chk("reset2_outputs", {busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    model_b = 0;
    run_frame(IN_W'($urandom), 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    b0 = model_b;

    obs_wr.delete();
    pi_end = 1'b1; s = cyc;
    @(posedge clk); #1 pi_end = 1'b0;
    n = 0;
    while (!oem_finish && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    chk("finish_seen", oem_finish, 1);
    chk("done_busy", busy, 1);
`ifdef STI_DAC_ZERO_FILL_EN
    chk("flush_count", obs_wr.size(), TOT - b0);
    mism = 0;
    for (int i = 0; i < obs_wr.size(); i++) begin
      n = b0 + i;
      if (obs_wr[i].data != 0 || obs_wr[i].bad || obs_wr[i].cyc != obs_wr[0].cyc + i ||
          obs_wr[i].bank != n / (2 * DEPTH) || obs_wr[i].addr != (n % (2 * DEPTH)) / 2 ||
          obs_wr[i].par != (((n % 2) ^ ((n / ROW_BYTES) % 2)) != 0)) mism++;
    end
    chk("flush_writes", mism, 0);
    if (obs_wr.size() > 0) chk("finish_after_last", cyc, obs_wr[obs_wr.size() - 1].cyc + 1);
`else
    chk("finish_cycle", cyc, s + 1);
    chk("no_fill_writes", obs_wr.size(), 0);
`endif

    obs_bits.delete(); obs_cyc.delete(); obs_wr.delete();
    pi_data = IN_W'($urandom); load = 1'b1; pi_end = 1'b1;
    @(posedge clk); #1 load = 1'b0; pi_end = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("done_no_serial", obs_bits.size(), 0);
    chk("done_no_write", obs_wr.size(), 0);
    chk("done_finish_sticky", oem_finish, 1);
    chk("done_busy_held", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
